// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel-rate counters, sync/blank decode and a
// registered colour stage that keeps sync and pixel data aligned.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       r_pix_en;
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic       r_frame_start;
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_visible;
    logic       w_hs;
    logic       w_vs;

    assign w_h_last  = (r_hc == H_LAST);
    assign w_v_last  = (r_vc == V_LAST);
    assign w_visible = (r_hc < H_VIS_END) && (r_vc < V_VIS_END);
    assign w_hs      = !((r_hc >= H_SYNC_START) && (r_hc < H_SYNC_END));
    assign w_vs      = !((r_vc >= V_SYNC_START) && (r_vc < V_SYNC_END));

    // Pixel enable alternates every Clk; it doubles as the exported pixel clock.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_pix_en) begin
            if (w_h_last) begin
                r_hc <= '0;
                if (w_v_last) begin
                    r_vc <= '0;
                end else begin
                    r_vc <= r_vc + 10'd1;
                end
            end else begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    // Output stage decodes the position before it advances, giving one pixel of latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else if (r_pix_en) begin
            r_hs      <= w_hs;
            r_vs      <= w_vs;
            r_blank_n <= w_visible;
            r_red     <= w_visible ? Red_in   : 8'h00;
            r_green   <= w_visible ? Green_in : 8'h00;
            r_blue    <= w_visible ? Blue_in  : 8'h00;
        end
    end

    // Single-Clk pulse: cleared on the following (non-pixel) edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= r_pix_en & w_h_last & w_v_last;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign pixel_clk   = r_pix_en;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank_n     = r_blank_n;
    assign frame_start = r_frame_start;
    assign VGA_R       = r_red;
    assign VGA_G       = r_green;
    assign VGA_B       = r_blue;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen with a reduced raster so whole frames fit in a short run.
module tb_vga_scan_gen;

    localparam int HV = 20;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 5;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FP = HT * VT;

    logic       Clk;
    logic       Reset;
    logic [7:0] Red_in;
    logic [7:0] Green_in;
    logic [7:0] Blue_in;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pixel_clk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       frame_start;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(DrawX), .DrawY(DrawY), .pixel_clk(pixel_clk),
        .hs(hs), .vs(vs), .blank_n(blank_n), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: k counts Clk edges since reset release; every second edge is a pixel step.
    int unsigned k;
    logic [7:0]  m_r, m_g, m_b;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            k   <= 0;
            m_r <= '0;
            m_g <= '0;
            m_b <= '0;
        end else begin
            k <= k + 1;
            if (((k + 1) % 2) == 0) begin
                m_r <= Red_in;
                m_g <= Green_in;
                m_b <= Blue_in;
            end
        end
    end

    function automatic logic [48:0] model_vec();
        int n, pos, q, qx, qy;
        logic e_hs, e_vs, e_bl, e_fs;
        logic [23:0] e_rgb;
        n   = int'(k / 2);
        pos = n % FP;
        e_fs = (k != 0) && ((k % 2) == 0) && (pos == 0);
        if (n == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = '0;
        end else begin
            q  = (n - 1) % FP;
            qx = q % HT;
            qy = q / HT;
            e_hs  = !(qx >= HV + HF && qx < HV + HF + HS);
            e_vs  = !(qy >= VV + VF && qy < VV + VF + VS);
            e_bl  = (qx < HV) && (qy < VV);
            e_rgb = e_bl ? {m_r, m_g, m_b} : 24'd0;
        end
        return {10'(pos % HT), 10'(pos / HT), 1'(k % 2), e_hs, e_vs, e_bl, e_fs, e_rgb};
    endfunction

    logic [48:0] w_act;
    assign w_act = {DrawX, DrawY, pixel_clk, hs, vs, blank_n, frame_start, VGA_R, VGA_G, VGA_B};

    always @(negedge Clk) begin
        check("scan", {15'd0, w_act}, {15'd0, model_vec()});
    end

    // Input driver: random colours, x-ramp on red, or solid white.
    initial begin
        Red_in = '0; Green_in = '0; Blue_in = '0;
        forever begin
            @(negedge Clk);
            case (mode)
                1: begin
                    Red_in   = DrawX[7:0];
                    Green_in = 8'($urandom);
                    Blue_in  = 8'($urandom);
                end
                2: begin
                    Red_in = 8'hFF; Green_in = 8'hFF; Blue_in = 8'hFF;
                end
                default: begin
                    Red_in   = 8'($urandom);
                    Green_in = 8'($urandom);
                    Blue_in  = 8'($urandom);
                end
            endcase
        end
    end

    task automatic wait_xy(input int x, input int y);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (DrawX == 10'(x) && DrawY == 10'(y)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_xy_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        int   x;
        int   y;
        logic e_hs;
        logic e_vs;
        logic e_bl;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int low, per, fsc, viol, vis;
        logic prev;
        bit found;

        tbl[0]  = '{0,  0,  1'b1, 1'b1, 1'b1};
        tbl[1]  = '{19, 11, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{20, 0,  1'b1, 1'b1, 1'b0};
        tbl[3]  = '{23, 5,  1'b1, 1'b1, 1'b0};
        tbl[4]  = '{24, 5,  1'b0, 1'b1, 1'b0};
        tbl[5]  = '{29, 5,  1'b0, 1'b1, 1'b0};
        tbl[6]  = '{30, 5,  1'b1, 1'b1, 1'b0};
        tbl[7]  = '{0,  12, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{0,  14, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{25, 15, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{10, 16, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{34, 18, 1'b1, 1'b1, 1'b0};

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Asynchronous reset mid-frame, then restart timing.
        wait_xy(30, 7);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_async", {15'd0, w_act}, {15'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0});
        repeat (2) @(negedge Clk);
        check("rst_held", {15'd0, w_act}, {15'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0});
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rel_edge1", {52'd0, DrawX, pixel_clk, frame_start}, {52'd0, 10'd0, 1'b1, 1'b0});
        @(posedge Clk); #1;
        check("rel_edge2", {52'd0, DrawX, pixel_clk, frame_start}, {52'd0, 10'd1, 1'b0, 1'b0});

        // hs begins two Clk after DrawX reaches the sync start; line length.
        wait_xy(HV + HF - 1, 3);
        wait_xy(HV + HF, 3);
        @(negedge Clk);
        check("hs_pre", {63'd0, hs}, 64'd1);
        @(negedge Clk);
        check("hs_start", {63'd0, hs}, 64'd0);
        low = 1; per = 0; prev = 1'b0; found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            per++;
            if (prev && !hs) begin
                found = 1'b1;
                break;
            end
            if (!hs) low++;
            prev = hs;
        end
        check("line_found", {63'd0, found}, 64'd1);
        check("hs_low_clk", 64'(low), 64'(2 * HS));
        check("line_period", 64'(per), 64'(2 * HT));

        // Two frames of vs timing and frame_start count.
        prev = vs; found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (prev && !vs) begin
                found = 1'b1;
                break;
            end
            prev = vs;
        end
        check("vs_fall_found", {63'd0, found}, 64'd1);
        for (int f = 0; f < 2; f++) begin
            low = 1; per = 0; fsc = 0; prev = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge Clk);
                per++;
                if (prev && !vs) break;
                if (!vs) low++;
                if (frame_start) fsc++;
                prev = vs;
            end
            check("vs_low_clk", 64'(low), 64'(2 * VS * HT));
            check("frame_period", 64'(per), 64'(2 * FP));
            check("frame_start_cnt", 64'(fsc), 64'd1);
        end

        // Frame wrap and line wrap.
        wait_xy(HT - 2, VT - 1);
        wait_xy(HT - 1, VT - 1);
        @(negedge Clk);
        check("wrap_hold", {43'd0, DrawX, DrawY, frame_start}, {43'd0, 10'(HT - 1), 10'(VT - 1), 1'b0});
        @(negedge Clk);
        check("wrap_frame", {43'd0, DrawX, DrawY, frame_start}, {43'd0, 10'd0, 10'd0, 1'b1});
        @(negedge Clk);
        check("fs_one_clk", {63'd0, frame_start}, 64'd0);
        wait_xy(HT - 2, 10);
        wait_xy(HT - 1, 10);
        repeat (2) @(negedge Clk);
        check("wrap_line", {44'd0, DrawX, DrawY}, {44'd0, 10'd0, 10'd11});

        // Table of positions: decoded sync/blank for that pixel after it is output.
        for (int t = 0; t < 12; t++) begin
            wait_xy(tbl[t].x, tbl[t].y);
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge Clk);
                if (DrawX != 10'(tbl[t].x)) begin
                    found = 1'b1;
                    break;
                end
            end
            check($sformatf("tbl%0d_found", t), {63'd0, found}, 64'd1);
            check($sformatf("tbl%0d_sync", t), {61'd0, hs, vs, blank_n}, {61'd0, tbl[t].e_hs, tbl[t].e_vs, tbl[t].e_bl});
        end

        // Random colours with occasional asynchronous resets.
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 799) == 0) begin
                #($urandom_range(1, 4));
                Reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
                Reset = 1'b0;
            end
        end

        // Solid white: colour only while visible.
        mode = 2;
        repeat (4) @(negedge Clk);
        viol = 0; vis = 0;
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge Clk);
            if (blank_n) vis++;
            if (blank_n && {VGA_R, VGA_G, VGA_B} != 24'hFFFFFF) viol++;
            if (!blank_n && {VGA_R, VGA_G, VGA_B} != 24'h000000) viol++;
        end
        check("blank_viol", 64'(viol), 64'd0);
        check("visible_clk", 64'(vis), 64'(2 * HV * VV));

        // Red ramp follows x of the pixel being output.
        mode = 1;
        repeat (4) @(negedge Clk);
        viol = 0;
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge Clk);
            if (blank_n && VGA_R != 8'(DrawX - 10'd1)) viol++;
        end
        check("align_viol", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Clk  input  1  system clock (50 MHz); the block's only clock.
REQ-010 Reset  input  1  reset, asynchronous and active-high.
REQ-011 Red_in, Green_in, Blue_in  input  8 each  pixel color from the color mapper for the current DrawX/DrawY.
REQ-012 DrawX  output  10  current horizontal counter (0..H_TOTAL-1).
REQ-013 DrawY  output  10  current vertical counter (0..V_TOTAL-1).
REQ-014 pixel_clk  output  1  pixel clock, Clk/2.
REQ-015 hs  output  1  horizontal sync, active-low.
REQ-016 vs  output  1  vertical sync, active-low.
REQ-017 blank_n  output  1  high while the output pixel is visible.
REQ-018 frame_start  output  1  one-Clk pulse at frame wrap.
REQ-019 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel color to the DAC.

Function
REQ-020 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-021 Internal pix_en SHALL toggle every Clk; pixel_clk SHALL equal pix_en, registered.
REQ-022 All counter and output-stage registers SHALL update only on Clk edges where pix_en=1.
REQ-023 On each pix_en edge, hc SHALL increment; at hc=H_TOTAL-1 it SHALL wrap to 0.
REQ-024 vc SHALL increment only when hc wraps; at vc=V_TOTAL-1 with hc wrap, vc SHALL wrap to 0.
REQ-025 DrawX SHALL equal hc and DrawY SHALL equal vc, both driven directly from registers.
REQ-026 Output stage, on each pix_en edge, SHALL capture state for the pre-advance position (hc,vc).
REQ-027 hs SHALL be 0 when hc is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751), and 1 otherwise.
REQ-028 vs SHALL be 0 when vc is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), and 1 otherwise.
REQ-029 blank_n SHALL be 1 only when hc<H_VISIBLE and vc<V_VISIBLE.
REQ-030 VGA_R/G/B SHALL capture Red_in/Green_in/Blue_in when the position is visible, and 0 otherwise.
REQ-031 Latency: pixel (x,y) SHALL appear on hs/vs/blank_n/VGA_* exactly one pixel period (2 Clk) after DrawX=x, DrawY=y; sync and color SHALL stay mutually aligned.
REQ-032 frame_start SHALL be 1 for exactly the one Clk following the pix_en edge where (hc,vc) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0), and 0 otherwise.
REQ-033 Counter arithmetic SHALL be 10-bit unsigned; no value >= H_TOTAL or V_TOTAL SHALL ever appear on DrawX or DrawY.

Reset
REQ-034 While Reset=1, regardless of Clk: hc=0, vc=0, pix_en=0, pixel_clk=0, hs=1, vs=1, blank_n=0, VGA_R/G/B=0, frame_start=0.
REQ-035 Reset asserted mid-line or mid-frame SHALL take effect immediately; counting after release SHALL restart from (0,0), with the first increment on the second Clk edge after release.
REQ-036 No frame_start pulse SHALL be generated by reset release itself.

Verification
REQ-037 Reset scenario: assert Reset with hc=300, vc=200 -> DrawX=0, DrawY=0, hs=vs=1, blank_n=0, VGA_*=0 with no Clk edge; after release, DrawX=1 after 2 Clk edges.
REQ-038 Line timing scenario: run one line -> hs low for exactly 192 Clk, starting 2 Clk after DrawX=656; line period 1600 Clk.
REQ-039 Frame timing scenario: run two frames -> vs low for exactly 2 lines (3200 Clk) per frame, frame period 840000 Clk, one frame_start per frame.
REQ-040 Wrap scenario: observe DrawX=799, DrawY=524 -> next pix_en edge gives DrawX=0, DrawY=0 with a frame_start pulse; observe DrawX=799, DrawY=10 -> next edge gives DrawX=0, DrawY=11.
REQ-041 Blanking scenario: hold Red_in=Green_in=Blue_in=8'hFF -> VGA_*=FF only while blank_n=1; VGA_*=00 for the pixels output after DrawX=640..799 or DrawY=480..524.
REQ-042 Alignment scenario: drive Red_in=DrawX[7:0] -> VGA_R at each output pixel equals that pixel's x[7:0] for all visible x.
